// File: rtl/fpu_resp_sequencer.sv
// In-order response sequencer: remembers which unit (APU/FPNEW) each granted
// request went to and returns unit responses to the core strictly in issue order.
module fpu_resp_sequencer #(
   parameter int DATA_WIDTH    = 32,
   parameter int FP_TYPE_WIDTH = 5,
   parameter int USFLAGS_WIDTH = 5,
   parameter int DEPTH         = 4,
   parameter int APU_ID        = 1,
   parameter int FPNEW_ID      = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       core_req_i,
   output logic                       core_gnt_o,
   input  logic [FP_TYPE_WIDTH-1:0]   core_type_i,
   output logic                       demux_req_o,
   input  logic                       demux_gnt_i,
   input  logic                       apu_rvalid_i,
   output logic                       apu_rready_o,
   input  logic [DATA_WIDTH-1:0]      apu_rdata_i,
   input  logic [USFLAGS_WIDTH-1:0]   apu_rflags_i,
   input  logic                       fpnew_rvalid_i,
   output logic                       fpnew_rready_o,
   input  logic [DATA_WIDTH-1:0]      fpnew_rdata_i,
   input  logic [USFLAGS_WIDTH-1:0]   fpnew_rflags_i,
   output logic                       core_rvalid_o,
   input  logic                       core_rready_i,
   output logic [DATA_WIDTH-1:0]      core_rdata_o,
   output logic [USFLAGS_WIDTH-1:0]   core_rflags_o,
   output logic [$clog2(DEPTH+1)-1:0] outstanding_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Handshakes: a transfer happens in a cycle where valid (req) and ready
   // (gnt) are both high; valid never depends on ready of the same channel.
   logic [DEPTH-1:0] id_mem;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic full;
   logic empty;
   logic head_apu;
   logic type_apu;
   logic type_fpnew;
   logic push;
   logic pop;

   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);
   assign head_apu   = id_mem[rd_ptr];
   assign type_apu   = (core_type_i == FP_TYPE_WIDTH'(APU_ID));
   assign type_fpnew = (core_type_i == FP_TYPE_WIDTH'(FPNEW_ID));

   assign demux_req_o = core_req_i & ~full;
   assign core_gnt_o  = demux_gnt_i & ~full;

   // Unknown types pass through to the demux but are never tracked.
   assign push = core_req_i & core_gnt_o & (type_apu | type_fpnew);
   assign pop  = core_rvalid_o & core_rready_i;

   assign outstanding_o = count;

   // Only the unit named by the FIFO head may hand over a response.
   always_comb begin
      core_rvalid_o  = 1'b0;
      core_rdata_o   = '0;
      core_rflags_o  = '0;
      apu_rready_o   = 1'b0;
      fpnew_rready_o = 1'b0;
      if (!empty) begin
         if (head_apu) begin
            core_rvalid_o = apu_rvalid_i;
            core_rdata_o  = apu_rdata_i;
            core_rflags_o = apu_rflags_i;
            apu_rready_o  = core_rready_i;
         end else begin
            core_rvalid_o  = fpnew_rvalid_i;
            core_rdata_o   = fpnew_rdata_i;
            core_rflags_o  = fpnew_rflags_i;
            fpnew_rready_o = core_rready_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_mem <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            id_mem[wr_ptr] <= type_apu;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_resp_sequencer.sv
// Bench for fpu_resp_sequencer: directed vector table, a steady push/pop run
// and randomized traffic against a queue-based issue-order model.
module tb_fpu_resp_sequencer;
   localparam int DW    = 32;
   localparam int TW    = 5;
   localparam int FW    = 5;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_req_i;
   logic          core_gnt_o;
   logic [TW-1:0] core_type_i;
   logic          demux_req_o;
   logic          demux_gnt_i;
   logic          apu_rvalid_i;
   logic          apu_rready_o;
   logic [DW-1:0] apu_rdata_i;
   logic [FW-1:0] apu_rflags_i;
   logic          fpnew_rvalid_i;
   logic          fpnew_rready_o;
   logic [DW-1:0] fpnew_rdata_i;
   logic [FW-1:0] fpnew_rflags_i;
   logic          core_rvalid_o;
   logic          core_rready_i;
   logic [DW-1:0] core_rdata_o;
   logic [FW-1:0] core_rflags_o;
   logic [CW-1:0] outstanding_o;

   int n_tests = 0;
   int n_fail  = 0;

   fpu_resp_sequencer #(
      .DATA_WIDTH(DW), .FP_TYPE_WIDTH(TW), .USFLAGS_WIDTH(FW),
      .DEPTH(DEPTH), .APU_ID(1), .FPNEW_ID(0)
   ) dut (
      .clk(clk), .rst(rst),
      .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_type_i(core_type_i),
      .demux_req_o(demux_req_o), .demux_gnt_i(demux_gnt_i),
      .apu_rvalid_i(apu_rvalid_i), .apu_rready_o(apu_rready_o),
      .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
      .fpnew_rvalid_i(fpnew_rvalid_i), .fpnew_rready_o(fpnew_rready_o),
      .fpnew_rdata_i(fpnew_rdata_i), .fpnew_rflags_i(fpnew_rflags_i),
      .core_rvalid_o(core_rvalid_o), .core_rready_i(core_rready_i),
      .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
      .outstanding_o(outstanding_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- driver ----------------
   // Flags are derived from data so that a flags mix-up shows as a data-like error.
   task automatic drive(input int req, input int ty, input int dg, input int av,
                        input int ad, input int fv, input int fd, input int rr);
      core_req_i     = req[0];
      core_type_i    = ty[TW-1:0];
      demux_gnt_i    = dg[0];
      apu_rvalid_i   = av[0];
      apu_rdata_i    = ad;
      apu_rflags_i   = ad[FW-1:0];
      fpnew_rvalid_i = fv[0];
      fpnew_rdata_i  = fd;
      fpnew_rflags_i = fd[FW-1:0];
      core_rready_i  = rr[0];
   endtask

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int req; int ty; int dg; int av; int ad; int fv; int fd; int rr;
      int e_gnt; int e_dreq; int e_rv; int e_rd; int e_ar; int e_fr; int e_out;
   } vec_t;

   vec_t vecs[18];

   // ---------------- scoreboard state ----------------
   logic [DW-1:0] exp_q[$];   // issue-order unit ids (1 = APU, 0 = FPNEW)

   initial begin
      logic [DW-1:0] head;
      logic [DW-1:0] e_rd;
      int req, ty, dg, av, ad, fv, fd, rr;
      logic e_gnt, e_rv;

      //              req ty dg av ad      fv fd    rr  gnt dreq rv rd      ar fr out
      vecs[0]  = '{1, 0, 1, 0, 0,      0, 0,    1,  1, 1, 0, 0,      0, 0, 0}; // issue FPNEW
      vecs[1]  = '{1, 1, 1, 1, 'hA,    0, 0,    1,  1, 1, 0, 0,      0, 1, 1}; // issue APU, APU answers early
      vecs[2]  = '{0, 0, 0, 1, 'hA,    0, 0,    1,  0, 0, 0, 0,      0, 1, 2}; // APU waits
      vecs[3]  = '{0, 0, 0, 1, 'hA,    1, 'hF,  1,  0, 0, 1, 'hF,    0, 1, 2}; // FPNEW first
      vecs[4]  = '{0, 0, 0, 1, 'hA,    0, 0,    1,  0, 0, 1, 'hA,    1, 0, 1}; // then APU
      vecs[5]  = '{0, 0, 0, 1, 5,      1, 6,    1,  0, 0, 0, 0,      0, 0, 0}; // empty stalls all
      vecs[6]  = '{1, 3, 0, 0, 0,      0, 0,    1,  0, 1, 0, 0,      0, 0, 0}; // unknown type forwarded
      vecs[7]  = '{1, 3, 1, 0, 0,      0, 0,    1,  1, 1, 0, 0,      0, 0, 0}; // unknown type not pushed
      vecs[8]  = '{0, 0, 0, 0, 0,      0, 0,    0,  0, 0, 0, 0,      0, 0, 0};
      vecs[9]  = '{1, 1, 1, 0, 0,      0, 0,    0,  1, 1, 0, 0,      0, 0, 0}; // fill to DEPTH
      vecs[10] = '{1, 1, 1, 0, 0,      0, 0,    0,  1, 1, 0, 0,      0, 0, 1};
      vecs[11] = '{1, 1, 1, 0, 0,      0, 0,    0,  1, 1, 0, 0,      0, 0, 2};
      vecs[12] = '{1, 1, 1, 0, 0,      0, 0,    0,  1, 1, 0, 0,      0, 0, 3};
      vecs[13] = '{1, 1, 1, 0, 0,      0, 0,    0,  0, 0, 0, 0,      0, 0, 4}; // full: no grant
      vecs[14] = '{0, 0, 0, 1, 'h1234, 0, 0,    0,  0, 0, 1, 'h1234, 0, 0, 4}; // held, rready low
      vecs[15] = '{0, 0, 0, 1, 'h1234, 0, 0,    0,  0, 0, 1, 'h1234, 0, 0, 4};
      vecs[16] = '{1, 0, 1, 1, 'h55,   0, 0,    1,  0, 0, 1, 'h55,   1, 0, 4}; // full+pop+req
      vecs[17] = '{1, 0, 1, 0, 0,      0, 0,    0,  1, 1, 0, 0,      0, 0, 3}; // grant next cycle

      do_reset();
      // rst still sampled high for two edges: check state while in reset
      rst = 1'b1;
      @(negedge clk);
      check("reset outstanding", DW'(outstanding_o), 0);
      check("reset gnt", DW'(core_gnt_o), 0);
      check("reset rvalid", DW'(core_rvalid_o), 0);
      check("reset rready", DW'({apu_rready_o, fpnew_rready_o}), 0);
      check("reset rdata", core_rdata_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].req, vecs[i].ty, vecs[i].dg, vecs[i].av, vecs[i].ad,
               vecs[i].fv, vecs[i].fd, vecs[i].rr);
         @(negedge clk);
         check($sformatf("v%0d gnt", i),   DW'(core_gnt_o),     DW'(vecs[i].e_gnt));
         check($sformatf("v%0d dreq", i),  DW'(demux_req_o),    DW'(vecs[i].e_dreq));
         check($sformatf("v%0d rvalid", i), DW'(core_rvalid_o), DW'(vecs[i].e_rv));
         check($sformatf("v%0d rdata", i), core_rdata_o,        DW'(vecs[i].e_rd));
         check($sformatf("v%0d rflags", i), DW'(core_rflags_o), DW'(vecs[i].e_rd & 'h1F));
         check($sformatf("v%0d apu_rready", i), DW'(apu_rready_o),   DW'(vecs[i].e_ar));
         check($sformatf("v%0d fpn_rready", i), DW'(fpnew_rready_o), DW'(vecs[i].e_fr));
         check($sformatf("v%0d outstanding", i), DW'(outstanding_o), DW'(vecs[i].e_out));
         @(posedge clk); #1;
      end

      // Steady push+pop: one entry in flight, both units always offering data.
      do_reset();
      exp_q.delete();
      drive(1, 1, 1, 0, 0, 0, 0, 0);
      exp_q.push_back(1);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         head = exp_q[0];
         drive(1, i % 2, 1, 1, 'hA00 + i, 1, 'hF00 + i, 1);
         @(negedge clk);
         e_rd = (head == 1) ? DW'('hA00 + i) : DW'('hF00 + i);
         check($sformatf("steady%0d outstanding", i), DW'(outstanding_o), 1);
         check($sformatf("steady%0d rdata", i), core_rdata_o, e_rd);
         check($sformatf("steady%0d gnt", i), DW'(core_gnt_o), 1);
         void'(exp_q.pop_front());
         exp_q.push_back(DW'(i % 2));
         @(posedge clk); #1;
      end

      // Randomized traffic against the issue-order queue model.
      do_reset();
      exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         req = int'($urandom_range(0, 1));
         ty  = int'($urandom_range(0, 4)) % 3;          // 2 is an unknown type
         dg  = int'($urandom_range(0, 3) != 0);
         av  = int'($urandom_range(0, 1));
         fv  = int'($urandom_range(0, 1));
         ad  = int'($urandom);
         fd  = int'($urandom);
         rr  = int'($urandom_range(0, 3) != 0);
         drive(req, ty, dg, av, ad, fv, fd, rr);
         @(negedge clk);
         e_gnt = (dg != 0) && (exp_q.size() < DEPTH);
         e_rv  = 1'b0;
         e_rd  = '0;
         if (exp_q.size() > 0) begin
            e_rv = (exp_q[0] == 1) ? (av != 0) : (fv != 0);
            e_rd = (exp_q[0] == 1) ? DW'(ad) : DW'(fd);
         end
         check("rand gnt", DW'(core_gnt_o), DW'(e_gnt));
         check("rand dreq", DW'(demux_req_o), DW'((req != 0) && (exp_q.size() < DEPTH)));
         check("rand rvalid", DW'(core_rvalid_o), DW'(e_rv));
         check("rand rdata", core_rdata_o, e_rd);
         check("rand rflags", DW'(core_rflags_o), e_rd & 'h1F);
         check("rand apu_rready", DW'(apu_rready_o),
               DW'((rr != 0) && exp_q.size() > 0 && exp_q[0] == 1));
         check("rand fpn_rready", DW'(fpnew_rready_o),
               DW'((rr != 0) && exp_q.size() > 0 && exp_q[0] == 0));
         check("rand outstanding", DW'(outstanding_o), DW'(exp_q.size()));
         if (e_rv && rr != 0) void'(exp_q.pop_front());
         if (req != 0 && e_gnt && ty != 2) exp_q.push_back(DW'(ty));
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
